gpr_writeback: RTL and testbench
================================

# gpr_writeback

Write-back unit: the sole producer of the GPR file's write port. It merges results from the single-cycle ALU path and the long-latency load/store path into one registered write per cycle (`gpr_we` / `gpr_write_id` / `gpr_write_val`). It also keeps a per-register busy scoreboard that the decode stage queries for RAW hazards. It sits between execute/memory and the GPR file.

## Interface

Parameters:
- `XLEN`, default `` `GPR_BITS ``: result/data width.
- `ID_W`, default `` `GPR_ID_BITS ``: register-id width.
- `NREGS`, default `` `GPR_NUM ``: number of GPRs; x0 is hard-wired zero.

Ports:
- `clk`, in, 1: single clock; all state changes on posedge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `issue_valid`, in, 1: an instruction with destination `issue_rd` enters execute.
- `issue_rd`, in, ID_W: destination to mark busy.
- `alu_valid`, in, 1: ALU result present; always accepted, no backpressure.
- `alu_rd`, in, ID_W: ALU destination register.
- `alu_val`, in, XLEN: ALU result.
- `lsu_valid`, in, 1: LSU result offered.
- `lsu_ready`, out, 1: LSU result accepted this cycle when high together with `lsu_valid`.
- `lsu_rd`, in, ID_W: LSU destination register.
- `lsu_val`, in, XLEN: LSU result.
- `gpr_we`, out, 1: registered write enable to the GPR file.
- `gpr_write_id`, out, ID_W: registered write id.
- `gpr_write_val`, out, XLEN: registered write value.
- `hz_id1`, in, ID_W: first hazard query id.
- `hz_id2`, in, ID_W: second hazard query id.
- `hz_busy1`, out, 1: combinational busy bit for `hz_id1`; always 0 for id 0.
- `hz_busy2`, out, 1: combinational busy bit for `hz_id2`; always 0 for id 0.

## Operation

- **State:** a one-entry LSU skid buffer (`buf_valid`, `buf_rd`, `buf_val`), the output write register, and a busy vector `busy[NREGS-1:1]`.
- **Ready:** `lsu_ready = !buf_valid`, purely combinational from state.
- **Per-cycle output selection, priority order:**
  1. ALU.
  2. Buffered LSU entry.
  3. Direct LSU handshake.
- **ALU/LSU collision:** if a direct LSU handshake occurs while `alu_valid` is high, the LSU result goes into the buffer. The buffer drains on the first cycle without `alu_valid`.
- **Starvation:** a continuous ALU stream starves the buffer. This is permitted; the pipeline guarantees gaps.
- **x0 destinations:** a result with rd=0 is accepted (ALU, or LSU handshake completes) but discarded. It produces no `gpr_we` and never enters the buffer.
- **Idle cycles:** when nothing is selected, `gpr_we` is 0 and id/val hold their previous values.
- **Scoreboard set:** `issue_valid` with rd≠0 sets `busy[rd]`.
- **Scoreboard clear:** a write clears `busy[id]` (clear point is defined under Timing).
- **Set/clear collision:** if set and clear hit the same id at the same edge, set wins.
- **Issue rule:** issuing to an already-busy rd is a protocol violation; decode stalls on `hz_busy`.
- **Reset:**
  - `gpr_we`=0, `gpr_write_id`=0, `gpr_write_val`=0.
  - `buf_valid`=0, so `lsu_ready`=1.
  - All `busy` bits = 0.
- **Reset mid-operation:** buffered and in-flight writes are dropped; the scoreboard is cleared.

## Timing

- **Latency:** a result accepted in cycle N appears with `gpr_we`=1 in cycle N+1. The GPR file commits it on the negedge of N+1.
- **Buffer path:** a buffered LSU result accepted in cycle N (with ALU in N) writes in cycle N+2 at the earliest. `lsu_ready`=0 during cycle N+1.
- **Throughput:** at most one write per cycle. The LSU sustains one result per cycle only when `alu_valid` is low.
- **Clear timing:** the clear edge depends on configuration (see Configuration).
- **Hazard outputs:** combinational from the `busy` vector; no input-to-output path from `issue_*`.

## Configuration

- Macro: `GPR_WB_EARLY_CLEAR_EN`.
- **Defined:** `busy[id]` clears at the same edge that loads the write register. `hz_busy` reads 0 during cycle N+1 (the `gpr_we` cycle). This relies on the GPR file's negedge write for same-cycle readback.
- **Undefined:** `busy[id]` clears one edge later. `hz_busy` reads 0 from cycle N+2. Use this for GPR files with a posedge write.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream with `buf_valid`=1 → after release, `gpr_we`=0, `lsu_ready`=1, `hz_busy1`=`hz_busy2`=0, no stale write.
- **ALU path:** issue rd=5; ALU writes x5=0xDEADBEEF in cycle 3 → `gpr_we`=1, id=5, val=0xDEADBEEF in cycle 4. `hz_busy1`(id 5)=0 in cycle 4 with the macro, cycle 5 without.
- **Collision:** ALU x3=1 and LSU x7=2 in the same cycle → write x3 next cycle, write x7 the cycle after; `lsu_ready`=0 for exactly one cycle.
- **ALU stream:** ALU valid for 4 consecutive cycles with the buffer full → buffer held, `lsu_ready`=0 throughout; buffered write emitted on the first idle cycle.
- **x0 discard:** ALU rd=0 val=0x55 and LSU rd=0 val=0xAA → both accepted, `gpr_we` stays 0; `hz_id1`=0 gives `hz_busy1`=0.
- **Set/clear race:** issue rd=9 on the same edge as the write clearing x9 → `busy[9]`=1 afterwards.

Source files
------------

// File: rtl/gpr_writeback.sv
// gpr_writeback: merges ALU and LSU results into one registered GPR write per cycle and keeps
// a per-register busy scoreboard. Define GPR_WB_EARLY_CLEAR_EN to clear busy on the write-load edge.
`ifndef GPR_BITS
`define GPR_BITS 32
`endif
`ifndef GPR_ID_BITS
`define GPR_ID_BITS 5
`endif
`ifndef GPR_NUM
`define GPR_NUM 32
`endif

module gpr_writeback #(
  parameter int unsigned XLEN  = `GPR_BITS,
  parameter int unsigned ID_W  = `GPR_ID_BITS,
  parameter int unsigned NREGS = `GPR_NUM
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [ID_W-1:0] issue_rd,
  input  logic            alu_valid,
  input  logic [ID_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_val,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [ID_W-1:0] lsu_rd,
  input  logic [XLEN-1:0] lsu_val,
  output logic            gpr_we,
  output logic [ID_W-1:0] gpr_write_id,
  output logic [XLEN-1:0] gpr_write_val,
  input  logic [ID_W-1:0] hz_id1,
  input  logic [ID_W-1:0] hz_id2,
  output logic            hz_busy1,
  output logic            hz_busy2
);
  localparam int unsigned NIDS = 2 ** ID_W;

  logic            buf_valid;
  logic [ID_W-1:0] buf_rd;
  logic [XLEN-1:0] buf_val;
  logic [NIDS-1:0] busy, busy_d;
  logic            lsu_hs;
  logic            we_d;
  logic [ID_W-1:0] id_d;
  logic [XLEN-1:0] val_d;
  logic            buf_load, buf_drain;
  logic            clr_en;
  logic [ID_W-1:0] clr_id;

  assign lsu_ready = !buf_valid;
  assign lsu_hs    = lsu_valid && lsu_ready;

  // ALU first, then the skid buffer, then a direct LSU handshake; rd=0 results vanish.
  always_comb begin
    we_d      = 1'b0;
    id_d      = gpr_write_id;
    val_d     = gpr_write_val;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    if (alu_valid) begin
      if (alu_rd != '0) begin
        we_d  = 1'b1;
        id_d  = alu_rd;
        val_d = alu_val;
      end
      buf_load = lsu_hs && (lsu_rd != '0);
    end else if (buf_valid) begin
      we_d      = 1'b1;
      id_d      = buf_rd;
      val_d     = buf_val;
      buf_drain = 1'b1;
    end else if (lsu_hs && (lsu_rd != '0)) begin
      we_d  = 1'b1;
      id_d  = lsu_rd;
      val_d = lsu_val;
    end
  end

`ifdef GPR_WB_EARLY_CLEAR_EN
  assign clr_en = we_d;
  assign clr_id = id_d;
`else
  assign clr_en = gpr_we;
  assign clr_id = gpr_write_id;
`endif

  // Set is applied after clear so a same-edge issue keeps the register busy.
  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_id] = 1'b0;
    if (issue_valid && (issue_rd != '0) && (32'(issue_rd) < NREGS)) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_we        <= 1'b0;
      gpr_write_id  <= '0;
      gpr_write_val <= '0;
      buf_valid     <= 1'b0;
      buf_rd        <= '0;
      buf_val       <= '0;
      busy          <= '0;
    end else begin
      gpr_we        <= we_d;
      gpr_write_id  <= id_d;
      gpr_write_val <= val_d;
      busy          <= busy_d;
      if (buf_load) begin
        buf_valid <= 1'b1;
        buf_rd    <= lsu_rd;
        buf_val   <= lsu_val;
      end else if (buf_drain) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign hz_busy1 = busy[hz_id1] && (hz_id1 != '0);
  assign hz_busy2 = busy[hz_id2] && (hz_id2 != '0);

endmodule

// File: tb/tb_gpr_writeback.sv
// Self-checking bench for gpr_writeback: directed table, hand sequences, and a randomized run
// against a queue-based reference model.
module tb_gpr_writeback;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned ID_W  = 5;
  localparam int unsigned NREGS = 32;
`ifdef GPR_WB_EARLY_CLEAR_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic [ID_W-1:0] issue_rd;
  logic            alu_valid;
  logic [ID_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_val;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [ID_W-1:0] lsu_rd;
  logic [XLEN-1:0] lsu_val;
  logic            gpr_we;
  logic [ID_W-1:0] gpr_write_id;
  logic [XLEN-1:0] gpr_write_val;
  logic [ID_W-1:0] hz_id1, hz_id2;
  logic            hz_busy1, hz_busy2;

  always #5 clk = ~clk;

  gpr_writeback #(.XLEN(XLEN), .ID_W(ID_W), .NREGS(NREGS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_val      (alu_val),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_val      (lsu_val),
    .gpr_we       (gpr_we),
    .gpr_write_id (gpr_write_id),
    .gpr_write_val(gpr_write_val),
    .hz_id1       (hz_id1),
    .hz_id2       (hz_id2),
    .hz_busy1     (hz_busy1),
    .hz_busy2     (hz_busy2)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_val = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic            av;
    logic [ID_W-1:0] ard;
    logic [XLEN-1:0] aval;
    logic            lv;
    logic [ID_W-1:0] lrd;
    logic [XLEN-1:0] lval;
    logic            exp_rdy;
    logic            exp_we;
    logic [ID_W-1:0] exp_id;
    logic [XLEN-1:0] exp_val;
  } vec_t;

  typedef struct packed {
    logic [ID_W-1:0] rd;
    logic [XLEN-1:0] val;
  } res_t;

  vec_t            vecs[12];
  res_t            pend[$];
  res_t            r_item;
  logic            m_we, n_we, acc;
  logic [ID_W-1:0] m_id, n_id, r;
  logic [XLEN-1:0] m_val, n_val;
  logic [31:0]     busy_m, nb;

  initial begin
    rst_n = 1'b0;
    hz_id1 = '0; hz_id2 = '0;
    idle_inputs();

    // Collision, ALU stream over a full buffer, then x0 discard.
    vecs[0]  = '{1, 3, 32'h1,  1, 7, 32'h2,  1, 1, 3, 32'h1};
    vecs[1]  = '{0, 0, 32'h0,  0, 0, 32'h0,  0, 1, 7, 32'h2};
    vecs[2]  = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 7, 32'h2};
    vecs[3]  = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 1, 1, 32'h11};
    vecs[4]  = '{1, 4, 32'h44, 1, 6, 32'h66, 0, 1, 4, 32'h44};
    vecs[5]  = '{1, 5, 32'h55, 1, 6, 32'h66, 0, 1, 5, 32'h55};
    vecs[6]  = '{1, 8, 32'h88, 0, 0, 32'h0,  0, 1, 8, 32'h88};
    vecs[7]  = '{1, 9, 32'h99, 1, 6, 32'h66, 0, 1, 9, 32'h99};
    vecs[8]  = '{0, 0, 32'h0,  1, 6, 32'h66, 0, 1, 2, 32'h22};
    vecs[9]  = '{0, 0, 32'h0,  1, 6, 32'h66, 1, 1, 6, 32'h66};
    vecs[10] = '{1, 0, 32'h55, 1, 0, 32'hAA, 1, 0, 6, 32'h66};
    vecs[11] = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 6, 32'h66};

    do_reset();
    chk("reset_we", gpr_we, 0);
    chk("reset_id", gpr_write_id, 0);
    chk("reset_val", gpr_write_val, 0);
    chk("reset_ready", lsu_ready, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_val = vecs[i].aval;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_val = vecs[i].lval;
      #1;
      chk($sformatf("vec%0d_ready", i), lsu_ready, vecs[i].exp_rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_we", i), gpr_we, vecs[i].exp_we);
      chk($sformatf("vec%0d_id", i), gpr_write_id, vecs[i].exp_id);
      chk($sformatf("vec%0d_val", i), gpr_write_val, vecs[i].exp_val);
    end
    @(negedge clk); idle_inputs();

    // ALU path with scoreboard timing.
    do_reset();
    hz_id1 = 5; hz_id2 = 0;
    issue_valid = 1'b1; issue_rd = 5;
    #1 chk("alu_busy_pre", hz_busy1, 0);
    @(negedge clk); issue_valid = 1'b0;
    #1 chk("alu_busy_set", hz_busy1, 1);
    chk("alu_hz2_x0", hz_busy2, 0);
    @(negedge clk); alu_valid = 1'b1; alu_rd = 5; alu_val = 32'hDEADBEEF;
    #1 chk("alu_busy_before_wr", hz_busy1, 1);
    @(posedge clk); #1;
    chk("alu_we", gpr_we, 1);
    chk("alu_id", gpr_write_id, 5);
    chk("alu_val", gpr_write_val, 32'hDEADBEEF);
    @(negedge clk); alu_valid = 1'b0;
    #1 chk("alu_busy_we_cycle", hz_busy1, EARLY ? 0 : 1);
    @(posedge clk); #1;
    chk("alu_we_drop", gpr_we, 0);
    chk("alu_busy_after", hz_busy1, 0);

    // Issue to x9 on the very edge that clears x9.
    @(negedge clk);
    hz_id1 = 9;
    alu_valid = 1'b1; alu_rd = 9; alu_val = 32'h9;
    issue_valid = EARLY; issue_rd = 9;
    @(negedge clk);
    alu_valid = 1'b0;
    issue_valid = !EARLY;
    @(negedge clk);
    issue_valid = 1'b0;
    #1 chk("race_busy9", hz_busy1, 1);

    // Reset while the buffer holds x7 and x12 is busy.
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 3; alu_val = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 7; lsu_val = 32'h2;
    issue_valid = 1'b1; issue_rd = 12;
    hz_id1 = 12; hz_id2 = 9;
    @(posedge clk); #1;
    idle_inputs();
    chk("rst_pre_buf_full", lsu_ready, 0);
    chk("rst_pre_busy12", hz_busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", gpr_we, 0);
    chk("rst_ready", lsu_ready, 1);
    chk("rst_busy1", hz_busy1, 0);
    chk("rst_busy2", hz_busy2, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_stale_we", gpr_we, 0);
    end

    // Randomized run against the reference model.
    do_reset();
    pend.delete();
    m_we = 0; m_id = 0; m_val = 0; busy_m = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = 5'($urandom_range(1, 31));
      issue_valid = ($urandom_range(0, 3) == 0) && !busy_m[r];
      issue_rd = r;
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_val = $urandom;
      lsu_valid = 1'($urandom_range(0, 1));
      lsu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lsu_val = $urandom;
      hz_id1 = 5'($urandom_range(0, 31));
      hz_id2 = 5'($urandom_range(0, 31));
      #1;
      chk("rnd_ready", lsu_ready, pend.size() == 0);
      chk("rnd_hz1", hz_busy1, busy_m[hz_id1]);
      chk("rnd_hz2", hz_busy2, busy_m[hz_id2]);

      acc = lsu_valid && (pend.size() == 0);
      n_we = 0; n_id = m_id; n_val = m_val;
      if (alu_valid) begin
        if (alu_rd != 0) begin n_we = 1; n_id = alu_rd; n_val = alu_val; end
        if (acc && lsu_rd != 0) pend.push_back('{rd: lsu_rd, val: lsu_val});
      end else if (pend.size() != 0) begin
        r_item = pend.pop_front();
        n_we = 1; n_id = r_item.rd; n_val = r_item.val;
      end else if (acc && lsu_rd != 0) begin
        n_we = 1; n_id = lsu_rd; n_val = lsu_val;
      end
      nb = busy_m;
      if (EARLY) begin
        if (n_we) nb[n_id] = 1'b0;
      end else if (m_we) begin
        nb[m_id] = 1'b0;
      end
      if (issue_valid) nb[issue_rd] = 1'b1;

      @(posedge clk); #1;
      m_we = n_we; m_id = n_id; m_val = n_val; busy_m = nb;
      chk("rnd_we", gpr_we, m_we);
      chk("rnd_id", gpr_write_id, m_id);
      chk("rnd_val", gpr_write_val, m_val);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
